// File: rtl/c5_adder_arbiter_if.sv
// c5_adder_arbiter_if: requester/consumer side bundle of the shared-adder arbiter.
// The master modport is the pipeline side (requesters plus result consumer).
// The slave modport is the arbiter.
interface c5_adder_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
);
  logic [N_REQ-1:0]       I_req;
  logic [N_REQ*WIDTH-1:0] I_a_bus;
  logic [N_REQ*WIDTH-1:0] I_b_bus;
  logic [N_REQ-1:0]       I_do_add;
  logic [N_REQ-1:0]       O_ack;
  logic [WIDTH:0]         O_result;
  logic [ID_W-1:0]        O_id;
  logic                   O_valid;
  logic                   I_ready;

  modport master (
    output I_req, I_a_bus, I_b_bus, I_do_add, I_ready,
    input  O_ack, O_result, O_id, O_valid
  );

  modport slave (
    input  I_req, I_a_bus, I_b_bus, I_do_add, I_ready,
    output O_ack, O_result, O_id, O_valid
  );
endinterface

// File: rtl/c5_adder_arbiter.sv
// c5_adder_arbiter: shares one c5_adder between N_REQ requesters.
// Accepts one request per operation, latches its operands, and presents a
// registered result tagged with the requester index under valid/ready.
// Build option: define C5_ADDER_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no round-robin pointer). Default is round-robin.

module c5_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             do_add,
  output logic [WIDTH:0]   sum
);
  // Add yields {carry,sum}; subtract wraps in WIDTH+1 bits so the top bit is the borrow.
  always_comb begin
    if (do_add) begin
      sum = {1'b0, a} + {1'b0, b};
    end else begin
      sum = {1'b0, a} - {1'b0, b};
    end
  end
endmodule

module c5_adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input logic               I_clk,
  input logic               I_reset,
  c5_adder_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, next_state_s;
  logic [ID_W-1:0]  grant_s;
  logic             any_req_s;
  logic             accept_s;
  logic [N_REQ-1:0] ack_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s;
  logic             sel_add_s;
  logic [WIDTH-1:0] a_r, b_r;
  logic             add_r;
  logic [ID_W-1:0]  gid_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   result_r;
  logic [ID_W-1:0]  id_r;
  logic             valid_r;
`ifndef C5_ADDER_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  ptr_r;
`endif

  assign any_req_s = |bus.I_req;

  // Pick the winner: lowest requesting index, overridden by the lowest one at or above the RR pointer.
  always_comb begin
    grant_s = {ID_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.I_req[i]) begin
        grant_s = ID_W'(i);
      end else begin
        grant_s = grant_s;
      end
    end
`ifndef C5_ADDER_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.I_req[i] && (i >= int'(ptr_r))) begin
        grant_s = ID_W'(i);
      end else begin
        grant_s = grant_s;
      end
    end
`endif
  end

  // Route the granted requester's operands to the latch inputs.
  always_comb begin
    sel_a_s   = {WIDTH{1'b0}};
    sel_b_s   = {WIDTH{1'b0}};
    sel_add_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s == ID_W'(i)) begin
        sel_a_s   = bus.I_a_bus[i*WIDTH +: WIDTH];
        sel_b_s   = bus.I_b_bus[i*WIDTH +: WIDTH];
        sel_add_s = bus.I_do_add[i];
      end else begin
        sel_a_s   = sel_a_s;
        sel_b_s   = sel_b_s;
        sel_add_s = sel_add_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: next_state_s = accept_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: next_state_s = ST_DONE;
      ST_DONE: begin
        if (bus.I_ready) begin
          next_state_s = accept_s ? ST_EXEC : ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE or when the held result is being taken; never in reset.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: accept_s = any_req_s;
      ST_DONE: accept_s = any_req_s & bus.I_ready;
      default: accept_s = 1'b0;
    endcase
    if (I_reset) begin
      accept_s = 1'b0;
    end else begin
      accept_s = accept_s;
    end
    ack_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      ack_s[i] = accept_s & (grant_s == ID_W'(i));
    end
  end

  assign bus.O_ack = ack_s;

`ifndef C5_ADDER_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      ptr_r <= {ID_W{1'b0}};
    end else if (accept_s) begin
      if (grant_s == ID_W'(N_REQ - 1)) begin
        ptr_r <= {ID_W{1'b0}};
      end else begin
        ptr_r <= grant_s + {{(ID_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Operand latch: sampled only at ack so later requester changes are ignored.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      add_r <= 1'b0;
      gid_r <= {ID_W{1'b0}};
    end else if (accept_s) begin
      a_r   <= sel_a_s;
      b_r   <= sel_b_s;
      add_r <= sel_add_s;
      gid_r <= grant_s;
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      add_r <= add_r;
      gid_r <= gid_r;
    end
  end

  c5_adder #(.WIDTH(WIDTH)) u_adder (
    .a      (a_r),
    .b      (b_r),
    .do_add (add_r),
    .sum    (sum_s)
  );

  // Result register: capture in EXEC, hold through backpressure, drop valid when taken.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      result_r <= {(WIDTH+1){1'b0}};
      id_r     <= {ID_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EXEC: begin
          result_r <= sum_s;
          id_r     <= gid_r;
          valid_r  <= 1'b1;
        end
        ST_DONE: begin
          valid_r <= bus.I_ready ? 1'b0 : valid_r;
        end
        default: begin
          valid_r <= valid_r;
        end
      endcase
    end
  end

  assign bus.O_result = result_r;
  assign bus.O_id     = id_r;
  assign bus.O_valid  = valid_r;
endmodule

// File: tb/tb_c5_adder_arbiter.sv
// tb_c5_adder_arbiter: directed corner cases plus randomized traffic, checked
// against a transaction-level model of the shared adder arbiter.
// Honors C5_ADDER_ARB_FIXED_PRIO_EN for the fixed-priority build.
module tb_c5_adder_arbiter;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c5_adder_arbiter_if #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) bus ();

  c5_adder_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) dut (
    .I_clk   (clk),
    .I_reset (rst),
    .bus     (bus.slave)
  );

  // requester-side stimulus
  logic         req_v [N];
  logic [W-1:0] a_v   [N];
  logic [W-1:0] b_v   [N];
  logic         add_v [N];
  logic         ready_v;

  // transaction-level model
  int           m_ptr;
  bit           m_exec;
  logic [W:0]   m_exec_res;
  int           m_exec_id;
  bit           m_valid;
  logic [W:0]   m_res;
  int           m_id;
  logic [N-1:0] m_ack;
  logic [N-1:0] dut_ack_seen;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic add);
    logic [63:0] r;
    r = add ? ({32'd0, a} + {32'd0, b}) : ({32'd0, a} - {32'd0, b});
    return r[W:0];
  endfunction

  function automatic int model_grant();
`ifdef C5_ADDER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (req_v[i]) return i;
`else
    for (int d = 0; d < N; d++) if (req_v[(m_ptr + d) % N]) return (m_ptr + d) % N;
`endif
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      bus.I_req[i]            = req_v[i];
      bus.I_a_bus[i*W +: W]   = a_v[i];
      bus.I_b_bus[i*W +: W]   = b_v[i];
      bus.I_do_add[i]         = add_v[i];
    end
    bus.I_ready = ready_v;
  endtask

  // One clock cycle: drive, check DUT against model, then advance the model across the edge.
  task automatic step();
    int g;
    bit acc;
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    apply_inputs();
    g   = model_grant();
    acc = !rst && (g >= 0) && !m_exec && (!m_valid || ready_v);
    m_ack = acc ? (one << g) : {N{1'b0}};
    #1;
    dut_ack_seen = bus.O_ack;
    check_val("ack", bus.O_ack, m_ack);
    check_val("valid", bus.O_valid, m_valid);
    if (m_valid) begin
      check_val("result", bus.O_result, m_res);
      check_val("id", bus.O_id, m_id);
    end
    @(posedge clk);
    if (rst) begin
      m_exec = 0; m_valid = 0; m_ptr = 0;
    end else begin
      if (m_valid && ready_v) m_valid = 0;
      if (m_exec) begin
        m_valid = 1; m_res = m_exec_res; m_id = m_exec_id; m_exec = 0;
      end
      if (acc) begin
        m_exec     = 1;
        m_exec_res = model_sum(a_v[g], b_v[g], add_v[g]);
        m_exec_id  = g;
        m_ptr      = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    ready_v = 1'b1;
    repeat (n) step();
  endtask

  task automatic run_single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic add, input logic [W:0] exp, input string tag);
    req_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; add_v[i] = add; ready_v = 1'b1;
    step();
    check_val({tag, "_ack"}, dut_ack_seen, 64'(1) << i);
    req_v[i] = 1'b0; a_v[i] = $urandom; b_v[i] = $urandom; add_v[i] = ~add;
    step();
    check_val({tag, "_valid_t2"}, bus.O_valid, 64'd1);
    check_val({tag, "_res"}, bus.O_result, exp);
    check_val({tag, "_id"}, bus.O_id, 64'(i));
    step();
  endtask

  initial begin
    int rr_seen [$];
    int exp_rr [4];
    logic [W:0] bp_exp;

    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; a_v[i] = 32'd0; b_v[i] = 32'd0; add_v[i] = 1'b0;
    end
    ready_v = 1'b0;
    m_ptr = 0; m_exec = 0; m_valid = 0; m_ack = {N{1'b0}};
    m_res = '0; m_id = 0; m_exec_res = '0; m_exec_id = 0;

    // reset, with a request held to show no ack during reset
    rst = 1'b1;
    req_v[0] = 1'b1;
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ack", bus.O_ack, 64'd0);
    check_val("rst_valid", bus.O_valid, 64'd0);
    check_val("rst_result", bus.O_result, 64'd0);
    check_val("rst_id", bus.O_id, 64'd0);
    rst = 1'b0;
    req_v[0] = 1'b0;

    // single operations and carry/borrow corners
    run_single(0, 32'd5, 32'd7, 1'b1, 33'h0_0000_000C, "single");
    run_single(1, 32'hFFFF_FFFF, 32'd1, 1'b1, 33'h1_0000_0000, "carry");
    run_single(0, 32'd3, 32'd5, 1'b0, 33'h1_FFFF_FFFE, "borrow");
    run_single(2, 32'd5, 32'd3, 1'b0, 33'h0_0000_0002, "sub");

    // req0 and req1 held continuously (pointer is 0 after the grant to 2)
`ifdef C5_ADDER_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0};
`else
    exp_rr = '{0, 1, 0, 1};
`endif
    ready_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b1; a_v[i] = $urandom; b_v[i] = $urandom; add_v[i] = 1'b1;
    end
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (dut_ack_seen[i]) rr_seen.push_back(i);
        if (m_ack[i]) begin a_v[i] = $urandom; b_v[i] = $urandom; end
      end
    end
    check_val("rr_count", 64'(rr_seen.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < rr_seen.size()) check_val($sformatf("rr_order%0d", k), 64'(rr_seen[k]), 64'(exp_rr[k]));
    end
    idle_cycles(3);

    // backpressure: result held five cycles while req1 waits, then taken with same-cycle ack1
    req_v[0] = 1'b1; a_v[0] = 32'h8000_0001; b_v[0] = 32'h8000_0002; add_v[0] = 1'b1;
    bp_exp = 33'h1_0000_0003;
    ready_v = 1'b1;
    step();
    req_v[0] = 1'b0;
    req_v[1] = 1'b1; a_v[1] = 32'd10; b_v[1] = 32'd20; add_v[1] = 1'b0;
    ready_v = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("bp_hold_res", bus.O_result, bp_exp);
      check_val("bp_hold_id", bus.O_id, 64'd0);
      check_val("bp_no_ack", dut_ack_seen, 64'd0);
    end
    ready_v = 1'b1;
    step();
    check_val("bp_ack1", dut_ack_seen, 64'd2);
    req_v[1] = 1'b0;
    idle_cycles(3);

    // reset while in EXEC: result dropped and pointer back to 0
    req_v[0] = 1'b1; req_v[1] = 1'b1; ready_v = 1'b1;
    a_v[0] = 32'd1; b_v[0] = 32'd2; a_v[1] = 32'd3; b_v[1] = 32'd4;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rstmid_valid", bus.O_valid, 64'd0);
    step();
    check_val("rstmid_ptr_ack0", dut_ack_seen, 64'd1);
    idle_cycles(4);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          req_v[i] = 1'b0; a_v[i] = $urandom; b_v[i] = $urandom; add_v[i] = 1'($urandom);
        end
        if (!req_v[i] && ($urandom_range(0, 2) == 0)) begin
          req_v[i] = 1'b1; a_v[i] = rand_operand(); b_v[i] = rand_operand();
          add_v[i] = 1'($urandom_range(0, 1));
        end else if (req_v[i] && ($urandom_range(0, 29) == 0)) begin
          req_v[i] = 1'b0;
        end
      end
      ready_v = ($urandom_range(0, 9) < 7);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
